// File: rtl/root_dispatch.sv
// rtl/root_dispatch.sv - Request FIFO plus issue/capture sequencer in front of the iterative root core
//
// root_dispatch_fifo: request queue, one push and one pop port, registered count.
//   push/wdata   write side (caller guarantees !full)
//   pop/rdata    read side, rdata is the current head (caller guarantees !empty)
//   empty/full   occupancy flags derived from the count register
//
// root_dispatch: top level.
//   req_valid/req_ready/req_radicand/req_degree/req_tag   request stream into the FIFO
//   rsp_valid/rsp_ready/rsp_data/rsp_tag/rsp_err          registered result slot
//   core_in_valid/core_in_data_1/core_in_data_2           start pulse and held operands to the core
//   core_out_valid/core_out_data                          single-cycle result strobe from the core
//   busy                                                  FSM not idle or FIFO non-empty
//
// Build option: define ROOT_DISPATCH_WDT_EN to add a BUSY watchdog of WDT_CYCLES cycles.

module root_dispatch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic         full
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);
endmodule

module root_dispatch #(
  parameter int DEPTH      = 4,
  parameter int TAG_W      = 4,
  parameter int WDT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [9:0]       req_radicand,
  input  logic [2:0]       req_degree,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [19:0]      rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err,
  output logic             core_in_valid,
  output logic [9:0]       core_in_data_1,
  output logic [2:0]       core_in_data_2,
  input  logic             core_out_valid,
  input  logic [19:0]      core_out_data,
  output logic             busy
);
  localparam int EW = 10 + 3 + TAG_W;

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;
  state_t state, state_nx;

  logic             push, pop, fifo_empty, fifo_full, slot_free;
  logic [EW-1:0]    head;
  logic [9:0]       head_rad;
  logic [2:0]       head_deg;
  logic [TAG_W-1:0] head_tag;
  logic [TAG_W-1:0] op_tag;
  logic             load_deg0, capture, timeout;

  // Full blocks a push even when a pop happens in the same cycle.
  assign req_ready = !fifo_full;
  assign push      = req_valid && req_ready;
  assign slot_free = !rsp_valid || rsp_ready;
  assign busy      = (state != IDLE) || !fifo_empty;
  assign {head_rad, head_deg, head_tag} = head;

  root_dispatch_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({req_radicand, req_degree, req_tag}),
    .pop   (pop),
    .rdata (head),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

`ifdef ROOT_DISPATCH_WDT_EN
  localparam int CW = $clog2(WDT_CYCLES + 1);
  localparam logic [CW-1:0] WDT_MAX = CW'(WDT_CYCLES);
  logic [CW-1:0] wdt_cnt;

  // Counts completed BUSY cycles; a pop is the only way into ISSUE, so clear there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              wdt_cnt <= '0;
    else if (pop)            wdt_cnt <= '0;
    else if (state == BUSY)  wdt_cnt <= wdt_cnt + 1'b1;
  end
`endif

  always_comb begin
    state_nx  = state;
    pop       = 1'b0;
    load_deg0 = 1'b0;
    capture   = 1'b0;
    timeout   = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty && slot_free) begin
          pop = 1'b1;
          if (head_deg == 3'd0) load_deg0 = 1'b1;
          else                  state_nx  = ISSUE;
        end
      end
      ISSUE: state_nx = BUSY;
      BUSY: begin
        if (core_out_valid) begin
          capture  = 1'b1;
          state_nx = IDLE;
        end
`ifdef ROOT_DISPATCH_WDT_EN
        else if (wdt_cnt == WDT_MAX) begin
          timeout  = 1'b1;
          state_nx = IDLE;
        end
`endif
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Operands change only on a pop, so they stay put through ISSUE and BUSY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_in_data_1 <= '0;
      core_in_data_2 <= '0;
      op_tag         <= '0;
      core_in_valid  <= 1'b0;
    end else begin
      core_in_valid <= pop && (head_deg != 3'd0);
      if (pop) begin
        core_in_data_1 <= head_rad;
        core_in_data_2 <= head_deg;
        op_tag         <= head_tag;
      end
    end
  end

  // Result slot: loads only happen when it was free at pop time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_tag   <= '0;
      rsp_err   <= 1'b0;
    end else if (load_deg0) begin
      rsp_valid <= 1'b1;
      rsp_data  <= '0;
      rsp_tag   <= head_tag;
      rsp_err   <= 1'b1;
    end else if (capture) begin
      rsp_valid <= 1'b1;
      rsp_data  <= core_out_data;
      rsp_tag   <= op_tag;
      rsp_err   <= 1'b0;
    end else if (timeout) begin
      rsp_valid <= 1'b1;
      rsp_data  <= 20'hFFFFF;
      rsp_tag   <= op_tag;
      rsp_err   <= 1'b1;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end
endmodule

// File: doc/root_dispatch.md
# root_dispatch

Request dispatcher sitting directly upstream of the iterative fixed-point root core. It buffers root requests (radicand, degree, tag) in a small FIFO and issues them to the core one at a time. While the core computes, it holds the core operands stable, which the core requires because it re-reads them every iteration. It captures the core's single-cycle result pulse into a result register with a valid/ready output, so downstream logic can apply backpressure.

## Interface
- DEPTH, 4: request FIFO entries; power of 2, ≥2.
- TAG_W, 4: width of the opaque request tag.
- WDT_CYCLES, 1024: watchdog limit in BUSY cycles; used only when the watchdog is compiled in.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  FIFO can accept a request.
- req_radicand  in  10  unsigned integer radicand.
- req_degree  in  3  root degree, 0..7.
- req_tag  in  TAG_W  returned unchanged with the result.
- rsp_valid  out  1  result present.
- rsp_ready  in  1  downstream accepts the result.
- rsp_data  out  20  Q10.10 root.
- rsp_tag  out  TAG_W  tag of the originating request.
- rsp_err  out  1  result is invalid (degree 0 or watchdog timeout).
- core_in_valid  out  1  one-cycle start pulse to the core.
- core_in_data_1  out  10  radicand to the core.
- core_in_data_2  out  3  degree to the core.
- core_out_valid  in  1  core result strobe, one cycle.
- core_out_data  in  20  core result, Q10.10.
- busy  out  1  high when the FSM is not in IDLE or the FIFO is non-empty.

## Operation
- Request push: on req_valid & req_ready, write {radicand, degree, tag} at wr_ptr. req_ready = (count != DEPTH). It does not depend on a same-cycle pop, so a full FIFO never accepts a push, even if a pop happens in that cycle.
- Pointers: log2(DEPTH) bits, wrapping naturally. count is log2(DEPTH)+1 bits. A simultaneous push and pop leaves count unchanged.
- Result slot is free when (!rsp_valid | rsp_ready).
- FSM states: IDLE, ISSUE, BUSY.
  - IDLE, FIFO non-empty and slot free: pop the head into the operand register (radicand, degree, tag).
    - degree == 0: write the result slot directly with data 0, err 1, tag. Stay in IDLE. No core pulse.
    - Otherwise go to ISSUE.
  - ISSUE: core_in_valid = 1 for exactly this one cycle. Go to BUSY.
  - BUSY: on core_out_valid, load rsp_data = core_out_data, rsp_tag = operand tag, rsp_err = 0. Go to IDLE.
- core_in_data_1/2 come from the operand register. They change only on a pop, so they stay stable from ISSUE through the capture cycle inclusive.
- The slot was free at issue and nothing else writes it, so a capture never overwrites an unconsumed result.
- A core_out_valid seen outside BUSY is discarded.
- rsp_* holds stable while rsp_valid & !rsp_ready. rsp_valid clears on rsp_ready unless the slot is reloaded in the same cycle.
- Degree 1 goes through the core like any other degree; the core returns radicand<<10.

## Timing
- All outputs are registered.
- Reset values: req_ready 1, rsp_valid 0, rsp_data 0, rsp_tag 0, rsp_err 0, core_in_valid 0, core_in_data_1 0, core_in_data_2 0, busy 0. FIFO empty, FSM in IDLE.
- Request accepted at cycle N: earliest pop at N+1, core_in_valid at N+2.
- Capture at cycle C: rsp_valid = 1 from C+1. Earliest next pop at C+1, if rsp_ready = 1 then or the slot is otherwise free. The core has returned to its idle state by then.
- Degree-0 request popped at cycle P: rsp_valid from P+1.
- Asserting rst_n low mid-operation immediately clears all state, including FIFO contents and any in-flight request. The core shares rst_n.

## Configuration
- ROOT_DISPATCH_WDT_EN defined:
  - A counter runs while in BUSY and clears on entering ISSUE.
  - After WDT_CYCLES BUSY cycles without core_out_valid: load rsp_data 20'hFFFFF, rsp_err 1, operand tag. Go to IDLE.
  - A late core_out_valid is discarded.
- ROOT_DISPATCH_WDT_EN undefined:
  - No counter is built. BUSY waits indefinitely.
  - rsp_err is set only for degree 0. WDT_CYCLES is ignored.

## Test plan
- Radicand 16, degree 2, tag 3, real core: single core_in_valid pulse with in_data_1 = 16 and in_data_2 = 2 held through the capture cycle. Response is rsp_data 0x01000, tag 3, err 0.
- Radicand 5, degree 0, tag 7: no core_in_valid. Response is rsp_data 0, tag 7, err 1, with rsp_valid two cycles after acceptance.
- Core model silent, 6 back-to-back requests: first issued, next 4 fill the FIFO, req_ready low for the 6th. The 6th is accepted only after the core responds and the next entry is popped.
- rsp_ready held 0 for 20 cycles with 2 queued requests: rsp_* stays constant and no core_in_valid is issued. Raising rsp_ready pops the next request in that same cycle.
- rst_n pulsed low during BUSY: all outputs go to reset values before the next clock edge. A later core_out_valid is ignored.
- With ROOT_DISPATCH_WDT_EN and WDT_CYCLES = 16, core silent: rsp_valid with data 0xFFFFF and err 1 appears 17 cycles after BUSY entry. A core_out_valid 5 cycles later is discarded.
